seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The parameter SHALL be N, default 5, giving the operand width in bits.
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit; reset is asynchronous and active-high.
REQ-004 Port start SHALL be input, 1 bit, a request to begin a division, sampled only in IDLE.
REQ-005 Port dividend SHALL be input, N bits, unsigned, sampled on the accepting edge.
REQ-006 Port divisor SHALL be input, N bits, unsigned, sampled on the accepting edge.
REQ-007 Port busy SHALL be output, 1 bit, high in CALC and DONE.
REQ-008 Port done SHALL be output, 1 bit, a single-cycle pulse when results become valid.
REQ-009 Port quotient SHALL be output, N bits, unsigned, registered.
REQ-010 Port remainder SHALL be output, N bits, unsigned, registered.
REQ-011 Port div_by_zero SHALL be output, 1 bit, registered, valid with done.

Function
REQ-012 The algorithm SHALL be restoring division over N iterations, one iteration per clk edge.
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 In IDLE with start=1 and divisor!=0, the FSM SHALL do the following on the same edge:
- latch the operands;
- clear the partial remainder (N+1 bits) and the iteration counter;
- enter CALC.
REQ-015 Each CALC iteration SHALL perform these steps:
- shift {partial remainder, dividend register} left by 1;
- trial-subtract divisor (zero-extended to N+1 bits) from the partial remainder;
- if there is no borrow, keep the difference and shift 1 into the quotient LSB; otherwise keep the shifted value and shift 0 into the quotient LSB.
REQ-016 The trial subtraction SHALL be computed as A + ~B with carry-in 1, at width N+1; carry-out=1 means no borrow.
REQ-017 After the Nth CALC edge (counter wraps from N-1), the FSM SHALL enter DONE.
REQ-018 In DONE, the outputs SHALL be as follows:
- done=1 for exactly one cycle;
- quotient and remainder carry the final values;
- the next edge returns the FSM to IDLE.
REQ-019 Latency SHALL be as follows: for a start accepted at edge k, done is high in the cycle after edge k+N and the FSM is in IDLE after edge k+N+1.
REQ-020 The quotient, remainder and div_by_zero outputs SHALL hold their values after DONE until the next accepted start.
REQ-021 Start SHALL be ignored in CALC and DONE, with no effect on the operation in progress or its result.
REQ-022 In IDLE with start=1 and divisor=0, the FSM SHALL go directly to DONE with quotient=all ones, remainder=dividend and div_by_zero=1.
REQ-023 div_by_zero SHALL be cleared on every accepted start with a nonzero divisor.
REQ-024 When dividend<divisor, the result SHALL be quotient=0 and remainder=dividend.
REQ-025 Input changes during CALC SHALL NOT affect the result.

Reset
REQ-026 While rst=1, the block SHALL hold state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, independent of clk.
REQ-027 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-028 After rst falls, the block SHALL accept start on the first rising clk edge.

Structure
REQ-029 The following SHALL live in a shared definitions file:
- state encodings IDLE/CALC/DONE;
- the default width N=5.
REQ-030 The trial subtractor SHALL be one instance of the team's existing Adder, with its width parameter set to N+1:
- A = partial remainder;
- B = inverted divisor;
- cin = 1;
- the MSB of out is used as the no-borrow flag.
REQ-031 The counter width SHALL be ceil(log2(N+1)) bits.

Verification
REQ-032 The bench SHALL cover start with dividend=30, divisor=7 -> done after 5 CALC edges; quotient=4, remainder=2, div_by_zero=0.
REQ-033 The bench SHALL cover dividend=31, divisor=1 -> quotient=31, remainder=0; and dividend=3, divisor=9 -> quotient=0, remainder=3.
REQ-034 The bench SHALL cover dividend=5, divisor=0 -> done one cycle after start; quotient=31, remainder=5, div_by_zero=1.
REQ-035 The bench SHALL cover start with 30/7, then start with 31/1 at CALC iteration 2 -> result still quotient=4, remainder=2; exactly one done pulse.
REQ-036 The bench SHALL cover rst asserted at CALC iteration 3 of 30/7 -> outputs immediately 0, no done pulse; then 31/1 -> quotient=31, remainder=0.
REQ-037 The bench SHALL cover two back-to-back divisions, with start re-asserted in the first IDLE cycle -> both results correct; each done is one cycle wide.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// State encodings and default operand width.
package seq_divider_pkg;

  localparam int N_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_adder.sv
// Generic ripple adder with carry-in; MSB of out is the carry-out.
// Used by the divider as its trial subtractor.
module seq_divider_adder #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W:0]   out
);

  assign out = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Dividend register doubles as the quotient shift register.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N:0]    prem;
  logic [N-1:0]  dreg;
  logic [N-1:0]  dsr;
  logic [CW-1:0] cnt;

  logic [N:0]    shifted;
  logic [N:0]    trial_b;
  logic [N+1:0]  sum;
  logic          nob;
  logic [N:0]    next_rem;
  logic [N-1:0]  next_q;

  // Partial remainder stays below the divisor, so its MSB drops out.
  assign shifted = {prem[N-1:0], dreg[N-1]};
  assign trial_b = ~{1'b0, dsr};

  seq_divider_adder #(
    .W (N + 1)
  ) u_sub (
    .a   (shifted),
    .b   (trial_b),
    .cin (1'b1),
    .out (sum)
  );

  assign nob      = sum[N+1];
  assign next_rem = nob ? sum[N:0] : shifted;
  assign next_q   = (dreg << 1) | N'(nob);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prem        <= '0;
      dreg        <= '0;
      dsr         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              dreg        <= dividend;
              dsr         <= divisor;
              prem        <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          prem <= next_rem;
          dreg <= next_q;
          if (cnt == LAST) begin
            cnt       <= '0;
            quotient  <= next_q;
            remainder <= next_rem[N-1:0];
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N=5).
// Each task drives one scenario and checks inline.
module tb_seq_divider;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  // Issue one start; returns edges from accept to done (-1 on timeout).
  // If inj >= 0, re-asserts start with 31/1 during the operation.
  task automatic go(input logic [N-1:0] a, input logic [N-1:0] b,
                    input int inj, output int edges);
    edges = -1;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start = 1'b0;
      if (i == inj) begin
        start = 1'b1;
        dividend = 5'd31;
        divisor  = 5'd1;
      end
      if (i == inj + 1) start = 1'b0;
      if (done) begin
        edges = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got %b want 000",
               {busy, done, div_by_zero});
    end
    tests++;
    if (quotient !== 5'd0 || remainder !== 5'd0) begin
      fails++;
      $display("FAIL reset_data got q=%0d r=%0d want 0 0",
               quotient, remainder);
    end
    tests++;
    if (dut.state !== seq_divider_pkg::IDLE || dut.cnt !== '0) begin
      fails++;
      $display("FAIL reset_state got st=%0d cnt=%0d want 0 0",
               dut.state, dut.cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e;
    go(5'd30, 5'd7, -1, e);
    tests++;
    if (e !== 5) begin
      fails++;
      $display("FAIL lat_30_7 got %0d want 5", e);
    end
    tests++;
    if (quotient !== 5'd4 || remainder !== 5'd2 ||
        div_by_zero !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL res_30_7 got q=%0d r=%0d z=%b b=%b want 4 2 0 1",
               quotient, remainder, div_by_zero, busy);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_width got d=%b b=%b want 0 0", done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (quotient !== 5'd4 || remainder !== 5'd2) begin
      fails++;
      $display("FAIL hold got q=%0d r=%0d want 4 2",
               quotient, remainder);
    end
  endtask

  task automatic test_edges();
    int e;
    go(5'd31, 5'd1, -1, e);
    tests++;
    if (e !== 5 || quotient !== 5'd31 || remainder !== 5'd0) begin
      fails++;
      $display("FAIL div_31_1 got e=%0d q=%0d r=%0d want 5 31 0",
               e, quotient, remainder);
    end
    @(posedge clk);
    go(5'd3, 5'd9, -1, e);
    tests++;
    if (e !== 5 || quotient !== 5'd0 || remainder !== 5'd3) begin
      fails++;
      $display("FAIL div_3_9 got e=%0d q=%0d r=%0d want 5 0 3",
               e, quotient, remainder);
    end
    @(posedge clk);
  endtask

  task automatic test_div_zero();
    int e;
    go(5'd5, 5'd0, -1, e);
    tests++;
    if (e !== 0) begin
      fails++;
      $display("FAIL lat_dbz got %0d want 0", e);
    end
    tests++;
    if (quotient !== 5'd31 || remainder !== 5'd5 ||
        div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL res_dbz got q=%0d r=%0d z=%b want 31 5 1",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    go(5'd30, 5'd7, -1, e);
    tests++;
    if (div_by_zero !== 1'b0 || quotient !== 5'd4) begin
      fails++;
      $display("FAIL dbz_clear got z=%b q=%0d want 0 4",
               div_by_zero, quotient);
    end
    @(posedge clk);
  endtask

  task automatic test_ignore_start();
    int e;
    done_cnt = 0;
    go(5'd30, 5'd7, 1, e);
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (e !== 5 || quotient !== 5'd4 || remainder !== 5'd2) begin
      fails++;
      $display("FAIL ignore got e=%0d q=%0d r=%0d want 5 4 2",
               e, quotient, remainder);
    end
    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL ignore_pulses got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int e;
    @(negedge clk);
    dividend = 5'd30;
    divisor  = 5'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    done_cnt = 0;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, div_by_zero} !== 3'b000 ||
        quotient !== 5'd0 || remainder !== 5'd0) begin
      fails++;
      $display("FAIL mid_rst got b=%b d=%b q=%0d r=%0d want 0 0 0 0",
               busy, done, quotient, remainder);
    end
    repeat (6) @(posedge clk);
    tests++;
    if (done_cnt !== 0) begin
      fails++;
      $display("FAIL mid_rst_pulse got %0d want 0", done_cnt);
    end
    @(negedge clk);
    dividend = 5'd31;
    divisor  = 5'd1;
    start    = 1'b1;
    rst      = 1'b0;
    e = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        e = i;
        break;
      end
    end
    tests++;
    if (e !== 5 || quotient !== 5'd31 || remainder !== 5'd0) begin
      fails++;
      $display("FAIL post_rst got e=%0d q=%0d r=%0d want 5 31 0",
               e, quotient, remainder);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    done_cnt = 0;
    go(5'd30, 5'd7, -1, e1);
    tests++;
    if (e1 !== 5 || quotient !== 5'd4 || remainder !== 5'd2) begin
      fails++;
      $display("FAIL b2b_first got e=%0d q=%0d r=%0d want 5 4 2",
               e1, quotient, remainder);
    end
    @(posedge clk);
    go(5'd23, 5'd4, -1, e2);
    tests++;
    if (e2 !== 5 || quotient !== 5'd5 || remainder !== 5'd3) begin
      fails++;
      $display("FAIL b2b_second got e=%0d q=%0d r=%0d want 5 5 3",
               e2, quotient, remainder);
    end
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (done_cnt !== 2) begin
      fails++;
      $display("FAIL b2b_pulses got %0d want 2", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
